// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display controller
// and its iterative binary-to-BCD converter.
package display_pkg;

    typedef enum logic {IDLE, CONV} conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BLANK_CODE = 4'hF;
    localparam int         NUM_DIGITS = 4;
    localparam int         CONV_ITERS = 10;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9
    // after the next doubling, so pre-add 3 to carry into the next digit.
    function automatic bcd_digit_t add3_adjust(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_shift_add3.sv
// Iterative shift-add-3 binary-to-BCD converter. done and bcd are presented
// combinationally on the final iteration so the caller can commit on that edge.
module bcd_shift_add3
    import display_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_bin,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam logic [3:0] ITER_LAST = 4'(CONV_ITERS - 1);

    logic [WIDTH-1:0] bin_reg;
    logic [15:0]      bcd_reg;
    logic [3:0]       iter_reg;
    logic             run_reg;

    logic [15:0]      adj;
    logic [15:0]      bcd_next;
    logic [WIDTH-1:0] bin_next;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = add3_adjust(bcd_reg[gi*4 +: 4]);
        end
    endgenerate

    assign {bcd_next, bin_next} = {adj, bin_reg} << 1;

    assign done = run_reg && (iter_reg == ITER_LAST);
    assign bcd  = bcd_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg  <= '0;
            bcd_reg  <= '0;
            iter_reg <= '0;
            run_reg  <= 1'b0;
        end else if (start) begin
            bin_reg  <= num_bin;
            bcd_reg  <= '0;
            iter_reg <= '0;
            run_reg  <= 1'b1;
        end else if (run_reg) begin
            bin_reg  <= bin_next;
            bcd_reg  <= bcd_next;
            iter_reg <= iter_reg + 4'd1;
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Accepts a binary value, converts it to BCD, commits it atomically to the
// display register and time-multiplexes the four digits onto the anodes.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int WIDTH    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] num_bin,
    input  logic             blank_lz,
    output logic             busy,
    output logic [3:0]       digit,
    output logic [3:0]       anodes
);

    localparam int         PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    conv_state_t   state_reg;
    logic [15:0]   display_reg;
    logic [PW-1:0] presc_reg;
    logic [1:0]    slot_reg;

    logic          accept;
    logic          conv_done;
    logic [15:0]   conv_bcd;

    assign load_ready = (state_reg == IDLE);
    assign busy       = ~load_ready;
    assign accept     = load_valid && load_ready;

    bcd_shift_add3 #(.WIDTH(WIDTH)) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .num_bin (num_bin),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            display_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (accept) state_reg <= CONV;
                CONV: if (conv_done) begin
                    display_reg <= conv_bcd;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Scanning is free-running and never waits on the conversion FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            slot_reg  <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
            slot_reg  <= slot_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    bcd_digit_t disp_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;

    // upper_zero[k]: this digit and every more-significant digit are zero.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
            assign disp_digits[gi] = display_reg[gi*4 +: 4];
            assign upper_zero[gi]  = (display_reg[4*NUM_DIGITS-1 : gi*4] == '0);
        end
    endgenerate

    always_comb begin
        digit  = disp_digits[slot_reg];
        anodes = ~(4'b0001 << slot_reg);
        if (blank_lz && (slot_reg != 2'd0) && upper_zero[slot_reg]) begin
            digit  = BLANK_CODE;
            anodes = 4'b1111;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed and randomized checks of display_scan_controller against a
// decimal-arithmetic model of the display, handshake and scan timing.
module tb_display_scan_controller;

    localparam int PRESCALE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [9:0] num_bin = '0;
    logic       blank_lz = 1'b0;
    logic       busy;
    logic [3:0] digit;
    logic [3:0] anodes;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // model state
    int cyc       = 0;
    int disp      = 0;
    int pend      = 0;
    int conv_left = 0;

    display_scan_controller #(.PRESCALE(PRESCALE), .WIDTH(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .num_bin    (num_bin),
        .blank_lz   (blank_lz),
        .busy       (busy),
        .digit      (digit),
        .anodes     (anodes)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected scan output from the displayed decimal value and the slot.
    task automatic check_outputs();
        int slot;
        int place;
        logic [3:0] exp_dg;
        logic [3:0] exp_an;
        slot  = (cyc / PRESCALE) % 4;
        place = 1;
        for (int i = 0; i < slot; i++) place = place * 10;
        exp_dg = 4'((disp / place) % 10);
        exp_an = 4'b1111 ^ (4'b0001 << slot);
        if (blank_lz && slot > 0 && disp < place) begin
            exp_dg = 4'hF;
            exp_an = 4'b1111;
        end
        check("load_ready", {3'b0, load_ready}, {3'b0, conv_left == 0});
        check("busy", {3'b0, busy}, {3'b0, conv_left != 0});
        check("digit", digit, exp_dg);
        check("anodes", anodes, exp_an);
    endtask

    task automatic tick();
        bit acc;
        acc = load_valid && (conv_left == 0);
        @(posedge clk);
        #1;
        cyc++;
        if (conv_left > 0) begin
            conv_left--;
            if (conv_left == 0) disp = pend;
        end else if (acc) begin
            conv_left = 10;
            pend      = int'(num_bin);
        end
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_pulse(input int v);
        load_valid = 1'b1;
        num_bin    = 10'(v);
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        // reset state
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // 1023: ready low 10 cycles, then a full scan of 16 cycles
        load_pulse(1023);
        ticks(10);
        ticks(16);

        // 7 with and without leading-zero blanking
        blank_lz = 1'b1;
        load_pulse(7);
        ticks(10 + 16);
        blank_lz = 1'b0;
        #1;
        check_outputs();
        ticks(16);

        // 0 with blanking: only units lit
        blank_lz = 1'b1;
        load_pulse(0);
        ticks(10 + 16);

        // 905: tens shows 0, thousands blanked
        load_pulse(905);
        ticks(10 + 16);

        // back-to-back 512 then 99 with load_valid held
        blank_lz   = 1'b0;
        load_valid = 1'b1;
        num_bin    = 10'd512;
        tick();
        num_bin = 10'd99;
        ticks(11);
        load_valid = 1'b0;
        check("second_accept_busy", {3'b0, busy}, 4'd1);
        ticks(10 + 8);
        check("after_99_display", 4'(disp == 99), 4'd1);

        // reset during iteration 5 of 888
        load_pulse(888);
        ticks(4);
        #2;
        rst = 1'b1;
        #1;
        cyc = 0; disp = 0; conv_left = 0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        ticks(20);

        // randomized loads
        for (int t = 0; t < 30; t++) begin
            int v;
            int gap;
            int guard;
            v        = int'($urandom_range(0, 1023));
            gap      = int'($urandom_range(0, 3));
            blank_lz = 1'($urandom_range(0, 1));
            ticks(gap);
            load_valid = 1'b1;
            num_bin    = 10'(v);
            guard      = 0;
            while (!(conv_left == 0) && guard < 20) begin
                tick();
                guard++;
            end
            tick();
            load_valid = 1'b0;
            ticks(int'($urandom_range(10, 30)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
